// File: rtl/mmu_pkg.sv
// Shared defaults and FSM state encoding for the MMU feeder.
package mmu_pkg;

   localparam int SIZE_DEF      = 4;
   localparam int BIT_WIDTH_DEF = 8;
   localparam int ARR_WIDTH_DEF = SIZE_DEF * BIT_WIDTH_DEF;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_BURST   = 3'd2,
      ST_SETTLE  = 3'd3,
      ST_STREAM  = 3'd4,
      ST_DRAIN   = 3'd5
   } state_t;

endpackage

// File: rtl/skew_line.sv
// Per-lane delay line of DEPTH registers (DEPTH >= 1), synchronously cleared.
module skew_line #(
   parameter int DEPTH = 1,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [DEPTH-1:0][W-1:0] sr_q, sr_d;

   always_comb begin
      sr_d    = sr_q;
      sr_d[0] = din;
      for (int i = 1; i < DEPTH; i++) sr_d[i] = sr_q[i-1];
   end

   always_ff @(posedge clk) begin
      if (rst) sr_q <= '0;
      else     sr_q <= sr_d;
   end

   assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/mmu_feeder.sv
// Weight/activation sequencer for the weight-stationary systolic MMU.
// Define FEEDER_SKEW_EN to diagonally skew data_arr lanes (lane k delayed k cycles).
module mmu_feeder
   import mmu_pkg::*;
#(
   parameter int SIZE      = SIZE_DEF,
   parameter int BIT_WIDTH = BIT_WIDTH_DEF,
   parameter int ARR_WIDTH = SIZE * BIT_WIDTH,
   parameter int WT_SETTLE = 2 * SIZE,
   parameter int DRAIN     = 2 * SIZE,
   parameter int ROW_CW    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [ROW_CW-1:0]    num_rows,
   input  logic                 wt_valid,
   output logic                 wt_ready,
   input  logic [ARR_WIDTH-1:0] wt_data,
   input  logic                 act_valid,
   output logic                 act_ready,
   input  logic [ARR_WIDTH-1:0] act_data,
   output logic                 control,
   output logic [ARR_WIDTH-1:0] wt_arr,
   output logic [ARR_WIDTH-1:0] data_arr,
   output logic                 data_vld,
   output logic                 busy,
   output logic                 done
);

`ifdef FEEDER_SKEW_EN
   localparam int SKEW_STEP = 1;
   localparam int DRAIN_LEN = DRAIN + SIZE - 1;
`else
   localparam int SKEW_STEP = 0;
   localparam int DRAIN_LEN = DRAIN;
`endif
   localparam int CNT_W = $clog2(SIZE + WT_SETTLE + DRAIN_LEN + 1) + 1;

   state_t                         state_q, state_d;
   logic [CNT_W-1:0]               cnt_q, cnt_d;
   logic [ROW_CW-1:0]              rcnt_q, rcnt_d;
   logic [ROW_CW-1:0]              rows_q, rows_d;
   logic [SIZE-1:0][ARR_WIDTH-1:0] wbuf_q, wbuf_d;
   logic                           wt_ready_q, wt_ready_d;
   logic                           act_ready_q, act_ready_d;
   logic                           control_q, control_d;
   logic [ARR_WIDTH-1:0]           wt_arr_q, wt_arr_d;
   logic [ARR_WIDTH-1:0]           data_d;
   logic                           data_vld_q, data_vld_d;
   logic                           busy_q, busy_d;
   logic                           done_q, done_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rcnt_d      = rcnt_q;
      rows_d      = rows_q;
      wbuf_d      = wbuf_q;
      wt_ready_d  = 1'b0;
      act_ready_d = 1'b0;
      control_d   = 1'b0;
      wt_arr_d    = '0;
      data_d      = '0;
      data_vld_d  = 1'b0;
      done_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_COLLECT;
               rows_d     = num_rows;
               cnt_d      = '0;
               rcnt_d     = '0;
               wt_ready_d = 1'b1;
            end
         end
         ST_COLLECT: begin
            wt_ready_d = 1'b1;
            if (wt_valid && wt_ready_q) begin
               for (int i = 0; i < SIZE; i++)
                  if (cnt_q == CNT_W'(i)) wbuf_d[i] = wt_data;
               if (cnt_q == CNT_W'(SIZE - 1)) begin
                  state_d    = ST_BURST;
                  cnt_d      = '0;
                  wt_ready_d = 1'b0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_BURST: begin
            control_d = 1'b1;
            for (int i = 0; i < SIZE; i++)
               if (cnt_q == CNT_W'(i)) wt_arr_d = wbuf_q[i];
            if (cnt_q == CNT_W'(SIZE - 1)) begin
               cnt_d   = '0;
               state_d = (rows_q == '0) ? ST_DRAIN : ST_SETTLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_SETTLE: begin
            // Leave two cycles early: ready registers one cycle, data one more.
            if (cnt_q == CNT_W'(WT_SETTLE - 2)) begin
               state_d     = ST_STREAM;
               cnt_d       = '0;
               act_ready_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_STREAM: begin
            act_ready_d = 1'b1;
            if (act_valid && act_ready_q) begin
               data_d     = act_data;
               data_vld_d = 1'b1;
               rcnt_d     = rcnt_q + ROW_CW'(1);
               if (rcnt_q + ROW_CW'(1) == rows_q) begin
                  state_d     = ST_DRAIN;
                  cnt_d       = '0;
                  act_ready_d = 1'b0;
               end
            end
         end
         ST_DRAIN: begin
            if (cnt_q == CNT_W'(DRAIN_LEN - 1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         rcnt_q      <= '0;
         rows_q      <= '0;
         wbuf_q      <= '0;
         wt_ready_q  <= 1'b0;
         act_ready_q <= 1'b0;
         control_q   <= 1'b0;
         wt_arr_q    <= '0;
         data_vld_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rcnt_q      <= rcnt_d;
         rows_q      <= rows_d;
         wbuf_q      <= wbuf_d;
         wt_ready_q  <= wt_ready_d;
         act_ready_q <= act_ready_d;
         control_q   <= control_d;
         wt_arr_q    <= wt_arr_d;
         data_vld_q  <= data_vld_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Each lane's delay line also provides the output register for data_arr.
   for (genvar k = 0; k < SIZE; k++) begin : g_lane
      skew_line #(.DEPTH(1 + SKEW_STEP * k), .W(BIT_WIDTH)) u_skew (
         .clk  (clk),
         .rst  (rst),
         .din  (data_d[k*BIT_WIDTH +: BIT_WIDTH]),
         .dout (data_arr[k*BIT_WIDTH +: BIT_WIDTH])
      );
   end

   assign wt_ready  = wt_ready_q;
   assign act_ready = act_ready_q;
   assign control   = control_q;
   assign wt_arr    = wt_arr_q;
   assign data_vld  = data_vld_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_mmu_feeder.sv
// Scoreboard bench for mmu_feeder: stimulus pushes expected rows, a negedge monitor checks them.
module tb_mmu_feeder;

   localparam int SIZE      = 4;
   localparam int BW        = 8;
   localparam int AW        = SIZE * BW;
   localparam int WT_SETTLE = 2 * SIZE;
   localparam int DRAIN     = 2 * SIZE;
`ifdef FEEDER_SKEW_EN
   localparam int DRAIN_LEN = DRAIN + SIZE - 1;
`else
   localparam int DRAIN_LEN = DRAIN;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [7:0]    num_rows = '0;
   logic          wt_valid = 1'b0;
   logic [AW-1:0] wt_data = '0;
   logic          act_valid = 1'b0;
   logic [AW-1:0] act_data = '0;
   logic          wt_ready, act_ready, control, data_vld, busy, done;
   logic [AW-1:0] wt_arr, data_arr;

   always #5 clk = ~clk;

   mmu_feeder #(.SIZE(SIZE), .BIT_WIDTH(BW), .ARR_WIDTH(AW), .WT_SETTLE(WT_SETTLE),
                .DRAIN(DRAIN), .ROW_CW(8)) dut (
      .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
      .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_data(wt_data),
      .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
      .control(control), .wt_arr(wt_arr), .data_arr(data_arr), .data_vld(data_vld),
      .busy(busy), .done(done)
   );

   int n_pass = 0, n_tot = 0, cyc = 0;
   logic [AW-1:0] wtq[$], actq[$];
   logic [AW-1:0] hist [0:1023];
   logic [AW-1:0] mon_e;
   int run, last_ctrl, first_vld, last_vld, nvld, ngaps, pend_gap, ndone, done_cyc;
   bit saw_ar;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic tmo(input string nm);
      n_tot++;
      $display("FAIL %s: timed out waiting (cycle %0d)", nm, cyc);
   endtask

   // Monitor: pops expectations whenever the DUT presents a weight or data beat.
   always @(negedge clk) begin
      if (!rst) begin
         hist[cyc & 1023] = data_arr;
         if (control) begin
            if (wtq.size() == 0) tmo("wt_arr_unexpected_beat");
            else begin mon_e = wtq.pop_front(); chk("wt_arr", wt_arr, mon_e); end
            run++;
            last_ctrl = cyc;
         end else begin
            if (run != 0) chk("burst_len", run, SIZE);
            run = 0;
            chk("wt_arr_idle_zero", wt_arr, 0);
         end
         if (data_vld) begin
            if (actq.size() == 0) tmo("data_arr_unexpected_beat");
            else begin
               mon_e = actq.pop_front();
`ifdef FEEDER_SKEW_EN
               chk("data_lane0", data_arr[BW-1:0], mon_e[BW-1:0]);
`else
               chk("data_arr", data_arr, mon_e);
`endif
            end
            if (first_vld < 0) first_vld = cyc;
            last_vld = cyc;
            nvld++;
            ngaps += pend_gap;
            pend_gap = 0;
         end else begin
            if (first_vld >= 0) pend_gap++;
`ifndef FEEDER_SKEW_EN
            chk("bubble_zero", data_arr, 0);
`endif
         end
         if (act_ready) saw_ar = 1'b1;
         if (done) begin ndone++; done_cyc = cyc; end
      end
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_wt_ready"}, wt_ready, 0);
      chk({tag, "_act_ready"}, act_ready, 0);
      chk({tag, "_control"}, control, 0);
      chk({tag, "_wt_arr"}, wt_arr, 0);
      chk({tag, "_data_arr"}, data_arr, 0);
      chk({tag, "_data_vld"}, data_vld, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wt_beat(input logic [AW-1:0] d);
      int i;
      wt_valid = 1'b1; wt_data = d; wtq.push_back(d);
      for (i = 0; i < 200; i++) begin @(negedge clk); if (wt_ready) break; end
      if (i == 200) tmo("wt_ready");
      @(posedge clk); #1;
      wt_valid = 1'b0; wt_data = '0;
   endtask

   task automatic act_beat(input logic [AW-1:0] d);
      int i;
      act_valid = 1'b1; act_data = d; actq.push_back(d);
      for (i = 0; i < 200; i++) begin @(negedge clk); if (act_ready) break; end
      if (i == 200) tmo("act_ready");
      @(posedge clk); #1;
      act_valid = 1'b0; act_data = '0;
   endtask

   task automatic wt_tile(input logic [AW-1:0] base);
      for (int i = 0; i < SIZE; i++) wt_beat(base + AW'(i));
   endtask

   task automatic begin_job(input int rows);
      run = 0; last_ctrl = -1; first_vld = -1; last_vld = -1; nvld = 0;
      ngaps = 0; pend_gap = 0; ndone = 0; done_cyc = -1; saw_ar = 1'b0;
      @(posedge clk); #1;
      num_rows = 8'(rows); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_start", busy, 1);
   endtask

   task automatic end_job(input int rows, input int gaps);
      int i;
      for (i = 0; i < 500; i++) begin @(negedge clk); if (done) break; end
      if (i == 500) tmo("done");
      @(posedge clk); #1;
      if (rows > 0) begin
         chk("settle_gap", first_vld - last_ctrl, WT_SETTLE);
         chk("drain_len", done_cyc - last_vld, DRAIN_LEN);
      end else begin
         chk("drain_len_no_rows", done_cyc - last_ctrl, DRAIN_LEN);
      end
      chk("valid_beats", nvld, rows);
      chk("bubble_cycles", ngaps, gaps);
      chk("done_pulses", ndone, 1);
      chk("act_ready_seen", saw_ar, rows > 0);
      chk("wt_queue_empty", wtq.size(), 0);
      chk("act_queue_empty", actq.size(), 0);
      chk("busy_after_done", busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [63:0] e;
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      rst = 1'b0;

      // basic job, back-to-back activations
      begin_job(3);
      wt_tile(32'h1000_0001);
      act_beat(32'h0A0B0C0D); act_beat(32'h11223344); act_beat(32'h55667788);
      end_job(3, 0);

      // weight stall pattern 1,0,0,1,1,0,1
      begin_job(2);
      wt_beat(32'h2000_0001); idle(2);
      wt_beat(32'h2000_0002); wt_beat(32'h2000_0003); idle(1);
      wt_beat(32'h2000_0004);
      act_beat(32'hCAFE0001); act_beat(32'hCAFE0002);
      end_job(2, 0);

      // two-cycle activation bubble mid-stream
      begin_job(4);
      wt_tile(32'h3000_0010);
      act_beat(32'h01010101); act_beat(32'h02020202); idle(2);
      act_beat(32'h03030303); act_beat(32'h04040404);
      end_job(4, 2);

      // weights only
      begin_job(0);
      wt_tile(32'h4000_0100);
      end_job(0, 0);

      // reset during STREAM aborts silently
      begin_job(3);
      wt_tile(32'h5000_0000);
      act_beat(32'hDEADBEEF); idle(2);
      rst = 1'b1;
      @(posedge clk); #1;
      chk_zero("abort");
      rst = 1'b0;
      idle(DRAIN_LEN + 4);
      chk("abort_no_done", ndone, 0);
      chk("abort_act_queue_empty", actq.size(), 0);

      // clean job after the abort
      begin_job(2);
      wt_tile(32'h6000_0000);
      act_beat(32'h600DF00D); act_beat(32'h12345678);
      end_job(2, 0);

      // single row {4,3,2,1}: lane placement
      begin_job(1);
      wt_tile(32'h7000_0000);
      act_beat(32'h04030201);
      end_job(1, 0);
`ifdef FEEDER_SKEW_EN
      for (int k = 0; k < SIZE; k++) begin
         e = 64'(k + 1) << (8 * k);
         chk("skew_lane", 64'(hist[(first_vld + k) & 1023]), e);
      end
`else
      chk("aligned_row", hist[first_vld & 1023], 32'h04030201);
      chk("aligned_next_zero", hist[(first_vld + 1) & 1023], 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
